interboard_link: RTL and testbench
==================================

Name: interboard_link

Overview:
- Point-to-point board-to-board link endpoint: a receive half and a transmit half in one clock domain.
- Receive half: registers 11-bit words arriving from the upstream board into a local receive FIFO write port; raises `read` (ready/credit) to upstream while that FIFO has room.
- Transmit half: pops words from a local show-ahead send FIFO while the downstream board asserts its ready; drives valid+data to that board.
- Sits between board-level I/O pins and the router's dual-clock FIFOs.

Parameters:
- DATA_W, 11, link word width.
- USEDW_W, 8, width of receive-FIFO wrusedw (256-deep FIFO).
- STOP_THRESH, 255, `read` deasserts when wrusedw >= STOP_THRESH.
- CNT_W, 32, statistics counter width (optional feature only).

Ports:
- transmit_clk  in  1  single link clock; also forwarded to neighbour boards.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  word-valid from upstream board.
- rx_data  in  DATA_W  word from upstream board.
- wrusedw  in  USEDW_W  receive-FIFO fill level.
- data  out  DATA_W  word to receive-FIFO write port.
- wrreq  out  1  receive-FIFO write request.
- read  out  1  ready to upstream board.
- fifo_data  in  DATA_W  send-FIFO q (show-ahead; valid while rdempty=0).
- read_input  in  1  ready from downstream board.
- rdempty  in  1  send-FIFO empty.
- tx_valid  out  1  word-valid to downstream board.
- tx_data  out  DATA_W  word to downstream board.
- rdreq  out  1  send-FIFO read request.

Behaviour:
- Single clock; reset is synchronous and active-high. All state updates on the rising edge of transmit_clk.
- Reset values: data=0, wrreq=0, read=0, tx_valid=0, tx_data=0. rdreq is forced 0 while reset=1.

Receive half:
- Each edge: data <= rx_data; wrreq <= rx_valid. Latency is 1 cycle; no filtering.
- Words arriving with rx_valid=1 are written even if the FIFO is reported full. Upstream is responsible for honouring `read`; STOP_THRESH provides slack for in-flight words.
- read <= (wrusedw < STOP_THRESH). Registered, so 1-cycle latency.
- With defaults: wrusedw=255 → read=0 next edge; wrusedw=254 → read=1 next edge.

Transmit half:
- rdreq = read_input & ~rdempty & ~reset. Combinational; pops the word currently on fifo_data.
- Each edge: tx_valid <= rdreq; tx_data <= rdreq ? fifo_data : tx_data. tx_data holds its last value when idle.
- read_input low or rdempty high stops popping immediately (same cycle). tx_valid drops on the next edge.

General:
- No internal state machine beyond these registers.
- Both halves run concurrently and independently; simultaneous rx and tx traffic has no interaction.
- Reset mid-transfer: the in-flight registered word is discarded (wrreq/tx_valid cleared). The send-FIFO word is not popped during reset.
- Loopback latency (tx_* → rx_*, read → read_input): rdreq at cycle N, tx_valid at N+1, wrreq at N+2.

Optional Feature:
- Macro INTERBOARD_STATS_EN.
- Defined: adds outputs rx_count[CNT_W] and tx_count[CNT_W].
  - rx_count increments on each edge where wrreq is being set (rx_valid=1).
  - tx_count increments on each edge where rdreq=1.
  - Both wrap modulo 2^CNT_W, reset to 0, and are read-only.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset held 5 cycles with wrusedw=0, rdempty=0, read_input=1, fifo_data=17 → all outputs 0 and rdreq=0 during reset; one edge after release read=1; rdreq=1 immediately after release.
- Loopback (tx_data/tx_valid → rx_data/rx_valid, read → read_input), fifo_data=17 → tx_valid=1 and tx_data=17 one cycle after rdreq; wrreq=1 and data=17 one cycle later, continuously.
- Flow control: set wrusedw=255 → read=0 one edge later; in loopback rdreq=0 the same cycle read_input falls; wrreq drops 2 cycles after that. Set wrusedw=254 → read=1 next edge and traffic resumes.
- rdempty=1 with read_input=1 → rdreq=0, tx_valid=0 next edge, tx_data holds 17.
- Reset asserted mid-stream → next edge wrreq=0, tx_valid=0, read=0; rdreq=0 during reset; traffic resumes after release.
- With INTERBOARD_STATS_EN: 10 popped words in loopback → tx_count=10 and rx_count=10 once drained.

Source files
------------

// File: rtl/interboard_link_if.sv
// Interface bundling the link endpoint's pin-side and FIFO-side signals.
// The endpoint connects through the slave modport. The board/FIFO environment
// connects through the master modport.
// When INTERBOARD_STATS_EN is defined, the interface also carries the
// rx_count/tx_count statistics outputs.
interface interboard_link_if #(
  parameter int DATA_W  = 11,
  parameter int USEDW_W = 8
`ifdef INTERBOARD_STATS_EN
  ,
  parameter int CNT_W   = 32
`endif
);
  // upstream board -> receive FIFO write port
  logic               rx_valid;
  logic [DATA_W-1:0]  rx_data;
  logic [USEDW_W-1:0] wrusedw;
  logic [DATA_W-1:0]  data;
  logic               wrreq;
  logic               read;

  // send FIFO (show-ahead) -> downstream board
  logic [DATA_W-1:0]  fifo_data;
  logic               read_input;
  logic               rdempty;
  logic               tx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               rdreq;

`ifdef INTERBOARD_STATS_EN
  logic [CNT_W-1:0]   rx_count;
  logic [CNT_W-1:0]   tx_count;
`endif

  modport slave (
    input  rx_valid, rx_data, wrusedw, fifo_data, read_input, rdempty,
    output data, wrreq, read, tx_valid, tx_data, rdreq
`ifdef INTERBOARD_STATS_EN
    ,
    output rx_count, tx_count
`endif
  );

  modport master (
    output rx_valid, rx_data, wrusedw, fifo_data, read_input, rdempty,
    input  data, wrreq, read, tx_valid, tx_data, rdreq
`ifdef INTERBOARD_STATS_EN
    ,
    input  rx_count, tx_count
`endif
  );
endinterface

// File: rtl/interboard_link.sv
// Board-to-board link endpoint.
// The receive half registers words from the upstream board into the local
// receive FIFO. It also holds `read` high while that FIFO has room.
// The transmit half pops the show-ahead send FIFO whenever the downstream
// board is ready, and drives the popped word out with a valid flag.
// The two halves are independent and share only the single link clock.
// Optional feature: defining INTERBOARD_STATS_EN adds wrapping
// rx_count/tx_count word counters.
module interboard_link #(
  parameter int DATA_W      = 11,
  parameter int USEDW_W     = 8,
  parameter int STOP_THRESH = 255
`ifdef INTERBOARD_STATS_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic               transmit_clk,
  input  logic               reset,
  interboard_link_if.slave   lnk
);

  localparam logic [DATA_W-1:0]  ZERO_WORD = '0;
  // One bit wider than wrusedw so that a threshold equal to 2**USEDW_W still
  // compares correctly. With that threshold, `read` never deasserts.
  localparam logic [USEDW_W:0]   STOP_LVL  = STOP_THRESH[USEDW_W:0];

  logic room_avail;

  // Free-space test for the registered `read`.
  always_comb begin
    room_avail = ({1'b0, lnk.wrusedw} < STOP_LVL);
  end

  // Pop the word currently shown on fifo_data. Popping is gated off while reset
  // is asserted, so the send FIFO keeps its head word.
  always_comb begin
    lnk.rdreq = lnk.read_input & ~lnk.rdempty & ~reset;
  end

  // Receive half: a one-cycle register stage into the FIFO write port.
  // There is deliberately no full check; STOP_THRESH leaves slack for words
  // already in flight.
  always_ff @(posedge transmit_clk) begin
    if (reset) begin
      lnk.data  <= ZERO_WORD;
      lnk.wrreq <= 1'b0;
      lnk.read  <= 1'b0;
    end else begin
      lnk.data  <= lnk.rx_data;
      lnk.wrreq <= lnk.rx_valid;
      lnk.read  <= room_avail;
    end
  end

  // Transmit half: register the popped word. tx_data holds its value when idle.
  always_ff @(posedge transmit_clk) begin
    if (reset) begin
      lnk.tx_valid <= 1'b0;
      lnk.tx_data  <= ZERO_WORD;
    end else begin
      lnk.tx_valid <= lnk.rdreq;
      if (lnk.rdreq) begin
        lnk.tx_data <= lnk.fifo_data;
      end
    end
  end

`ifdef INTERBOARD_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Word statistics; both counters wrap naturally at 2**CNT_W.
  always_ff @(posedge transmit_clk) begin
    if (reset) begin
      lnk.rx_count <= '0;
      lnk.tx_count <= '0;
    end else begin
      if (lnk.rx_valid) begin
        lnk.rx_count <= lnk.rx_count + CNT_ONE;
      end
      if (lnk.rdreq) begin
        lnk.tx_count <= lnk.tx_count + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_interboard_link.sv
// Directed testbench for interboard_link, with optional loopback wiring:
// tx_valid/tx_data feed rx_valid/rx_data, and read feeds read_input.
module tb_interboard_link;

  logic clk;
  logic reset;
  logic loop_en;
  logic       rx_valid_drv;
  logic [10:0] rx_data_drv;
  logic       read_input_drv;

  int n_tests;
  int n_fail;

  interboard_link_if lnk ();

  interboard_link dut (
    .transmit_clk (clk),
    .reset        (reset),
    .lnk          (lnk)
  );

  assign lnk.rx_valid   = loop_en ? lnk.tx_valid : rx_valid_drv;
  assign lnk.rx_data    = loop_en ? lnk.tx_data  : rx_data_drv;
  assign lnk.read_input = loop_en ? lnk.read     : read_input_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one rising edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    loop_en = 1'b0;
    rx_valid_drv = 1'b0;
    rx_data_drv = '0;
    read_input_drv = 1'b1;
    lnk.wrusedw = 8'd0;
    lnk.rdempty = 1'b0;
    lnk.fifo_data = 11'd17;

    // reset held 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_data", lnk.data, 0);
      chk("rst_wrreq", lnk.wrreq, 0);
      chk("rst_read", lnk.read, 0);
      chk("rst_tx_valid", lnk.tx_valid, 0);
      chk("rst_tx_data", lnk.tx_data, 0);
      chk("rst_rdreq", lnk.rdreq, 0);
    end

    reset = 1'b0;
    #1;
    chk("rel_rdreq", lnk.rdreq, 1);
    chk("rel_read_pre", lnk.read, 0);
    tick();
    chk("rel_read", lnk.read, 1);
    chk("rel_tx_valid", lnk.tx_valid, 1);
    chk("rel_tx_data", lnk.tx_data, 17);

    // loopback with a sequence of words: tx after 1 edge, rx after 2 edges
    loop_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      lnk.fifo_data = 11'(20 + i);
      tick();
      chk("lb_tx_valid", lnk.tx_valid, 1);
      chk("lb_tx_data", lnk.tx_data, 32'(20 + i));
      chk("lb_wrreq", lnk.wrreq, 1);
      chk("lb_data", lnk.data, (i == 0) ? 32'd17 : 32'(19 + i));
    end
    lnk.fifo_data = 11'd17;
    tick();
    tick();
    chk("lb17_data", lnk.data, 17);

    // flow control: stop at threshold
    lnk.wrusedw = 8'd255;
    tick();
    chk("fc_read_lo", lnk.read, 0);
    chk("fc_rdreq_lo", lnk.rdreq, 0);
    chk("fc_tx_valid1", lnk.tx_valid, 1);
    chk("fc_wrreq1", lnk.wrreq, 1);
    tick();
    chk("fc_tx_valid0", lnk.tx_valid, 0);
    chk("fc_wrreq2", lnk.wrreq, 1);
    tick();
    chk("fc_wrreq0", lnk.wrreq, 0);
    chk("fc_tx_hold", lnk.tx_data, 17);
    lnk.wrusedw = 8'd254;
    tick();
    chk("fc_read_hi", lnk.read, 1);
    chk("fc_rdreq_hi", lnk.rdreq, 1);
    tick();
    chk("fc_tx_resume", lnk.tx_valid, 1);
    tick();
    chk("fc_rx_resume", lnk.wrreq, 1);
    lnk.wrusedw = 8'd0;

    // send FIFO empty: no pop, tx_data holds even if q changes
    lnk.rdempty = 1'b1;
    lnk.fifo_data = 11'd99;
    #1;
    chk("emp_rdreq", lnk.rdreq, 0);
    tick();
    chk("emp_tx_valid", lnk.tx_valid, 0);
    chk("emp_tx_data", lnk.tx_data, 17);
    tick();
    chk("emp_wrreq", lnk.wrreq, 0);
    lnk.rdempty = 1'b0;
    lnk.fifo_data = 11'd17;
    tick();
    tick();
    chk("emp_resume", lnk.wrreq, 1);

    // reset mid-stream
    reset = 1'b1;
    #1;
    chk("mid_rdreq", lnk.rdreq, 0);
    tick();
    chk("mid_wrreq", lnk.wrreq, 0);
    chk("mid_tx_valid", lnk.tx_valid, 0);
    chk("mid_read", lnk.read, 0);
    reset = 1'b0;
    #1;
    chk("mid_rdreq_rel", lnk.rdreq, 0);
    tick();
    chk("mid_read_rel", lnk.read, 1);
    chk("mid_rdreq_go", lnk.rdreq, 1);
    tick();
    chk("mid_tx_go", lnk.tx_valid, 1);
    chk("mid_tx_data", lnk.tx_data, 17);
    tick();
    chk("mid_rx_go", lnk.wrreq, 1);
    chk("mid_rx_data", lnk.data, 17);

    // non-loopback receive path direct check
    loop_en = 1'b0;
    read_input_drv = 1'b0;
    rx_valid_drv = 1'b1;
    rx_data_drv = 11'h5a5;
    #1;
    chk("nl_rdreq", lnk.rdreq, 0);
    tick();
    chk("nl_wrreq", lnk.wrreq, 1);
    chk("nl_data", lnk.data, 32'h5a5);
    rx_valid_drv = 1'b0;
    rx_data_drv = 11'h7ff;
    tick();
    chk("nl_wrreq0", lnk.wrreq, 0);
    chk("nl_data2", lnk.data, 32'h7ff);

`ifdef INTERBOARD_STATS_EN
    // exactly 10 popped words in loopback
    loop_en = 1'b1;
    lnk.rdempty = 1'b1;
    reset = 1'b1;
    tick();
    chk("st_rx_rst", lnk.rx_count, 0);
    chk("st_tx_rst", lnk.tx_count, 0);
    reset = 1'b0;
    tick();
    lnk.rdempty = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    lnk.rdempty = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("st_tx_count", lnk.tx_count, 10);
    chk("st_rx_count", lnk.rx_count, 10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
